dbg_reg_writer: RTL and testbench

Debug write-side companion to the register-file display path on the FPGA board. The display path reads a register through the third RF read port (ra3/rd3). This block lets the operator key in a 32-bit value one hex nibble at a time from switches and debounced buttons. It then writes the value into a chosen register through a request/acknowledge debug write port on the RF. It sits in the board top alongside the button debouncer and the LED mux, and feeds its partial value to the 7-segment display select logic.

---
 rtl/dbg_reg_writer_if.sv | 18 +
 rtl/dbg_reg_writer.sv | 174 +++++++++++++++++
 tb/tb_dbg_reg_writer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_reg_writer_if.sv
// Debug write port between dbg_reg_writer (master) and the register file
// (slave).
//   wr_req  : write request, held until accepted
//   wr_addr : target register, stable while wr_req is high
//   wr_data : write data, stable while wr_req is high
//   wr_ack  : RF accepts in any cycle where wr_req && wr_ack
interface dbg_reg_writer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/dbg_reg_writer.sv
// Operator-driven debug register writer. A 32-bit value is keyed in one hex
// nibble per rising edge of btn_enter_i, then written into register addr_i
// through a req/ack port on a rising edge of btn_commit_i.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   mode_en_i       : entry enabled while high; low clears the partial value
//   digit_i         : nibble shifted in on an enter edge
//   addr_i          : target register, latched on a commit edge
//   btn_enter_i     : debounced enter button level
//   btn_commit_i    : debounced commit button level
//   disp_hi_i       : selects upper/lower 16 bits of the value for display
//   wr_if           : debug write port (master side)
//   disp_val_o      : registered display half of the shift register
//   nib_cnt_o       : nibbles entered, saturating at NIB_MAX
//   busy_o          : high while a write is in flight (REQ/DONE)
//   done_o          : one-cycle pulse after an accepted write
//   err_o           : one-cycle pulse when a commit targets register 0
module dbg_reg_writer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NIB_MAX = DATA_W / 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mode_en_i,
  input  logic [3:0]         digit_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic               btn_enter_i,
  input  logic               btn_commit_i,
  input  logic               disp_hi_i,
  dbg_reg_writer_if.master   wr_if,
  output logic [15:0]        disp_val_o,
  output logic [3:0]         nib_cnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [3:0] NIB_MAX_C = 4'(NIB_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_REQ,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              enter_prev_q, commit_prev_q;
  logic              enter_edge, commit_edge;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shifted;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_q, err_d;
  logic [15:0]       disp_q, disp_d;
  logic [31:0]       shift32;
  logic              req_c, busy_c, done_c;

  // Prev flops reset high so a button held through reset yields no edge.
  assign enter_edge  = btn_enter_i  & ~enter_prev_q;
  assign commit_edge = btn_commit_i & ~commit_prev_q;
  assign shifted     = {shift_q[DATA_W-5:0], digit_i};

  // Display always shows the low 32 bits of the value.
  assign shift32 = 32'(shift_q);
  assign disp_d  = disp_hi_i ? shift32[31:16] : shift32[15:0];

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      enter_prev_q  <= 1'b1;
      commit_prev_q <= 1'b1;
      shift_q       <= '0;
      cnt_q         <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      err_q         <= 1'b0;
      disp_q        <= '0;
    end else begin
      state_q       <= state_d;
      enter_prev_q  <= btn_enter_i;
      commit_prev_q <= btn_commit_i;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      err_q         <= err_d;
      disp_q        <= disp_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!mode_en_i) begin
          shift_d = '0;
          cnt_d   = '0;
        end else if (enter_edge) begin
          shift_d = shifted;
          cnt_d   = 4'd1;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (!mode_en_i) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (commit_edge) begin
          // Commit beats a simultaneous enter: the new nibble is dropped.
          wr_addr_d = addr_i;
          wr_data_d = shift_q;
          if (addr_i == '0) begin
            err_d   = 1'b1;
            shift_d = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_REQ;
          end
        end else if (enter_edge) begin
          shift_d = shifted;
          cnt_d   = (cnt_q == NIB_MAX_C) ? cnt_q : cnt_q + 4'd1;
        end
      end
      S_REQ: begin
        if (wr_if.wr_ack) state_d = S_DONE;
      end
      S_DONE: begin
        shift_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_c  = 1'b0;
    busy_c = 1'b0;
    done_c = 1'b0;
    unique case (state_q)
      S_REQ: begin
        req_c  = 1'b1;
        busy_c = 1'b1;
      end
      S_DONE: begin
        busy_c = 1'b1;
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_if.wr_req  = req_c;
  assign wr_if.wr_addr = wr_addr_q;
  assign wr_if.wr_data = wr_data_q;
  assign busy_o        = busy_c;
  assign done_o        = done_c;
  assign err_o         = err_q;
  assign nib_cnt_o     = cnt_q;
  assign disp_val_o    = disp_q;

endmodule

// File: tb/tb_dbg_reg_writer.sv
module tb_dbg_reg_writer;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NIB_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, mode_en, btn_enter, btn_commit, disp_hi, ack;
  logic [3:0]        digit;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       disp_val;
  logic [3:0]        nib_cnt;
  logic              busy, done, err;

  dbg_reg_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();
  assign wr_if.wr_ack = ack;

  dbg_reg_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NIB_MAX(NIB_MAX)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mode_en_i   (mode_en),
    .digit_i     (digit),
    .addr_i      (addr),
    .btn_enter_i (btn_enter),
    .btn_commit_i(btn_commit),
    .disp_hi_i   (disp_hi),
    .wr_if       (wr_if),
    .disp_val_o  (disp_val),
    .nib_cnt_o   (nib_cnt),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the entered value is the list of the most recent
  // nibbles; "in entry" simply means at least one nibble has been keyed.
  int          nibs[$];
  bit          m_prev_e, m_prev_c;
  bit          m_waiting, m_finishing, m_err;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [15:0] m_disp;

  function automatic logic [31:0] m_value();
    logic [31:0] v = '0;
    foreach (nibs[i]) v = (v << 4) | 32'(nibs[i]);
    return v;
  endfunction

  task automatic model_reset();
    nibs.delete();
    m_prev_e = 1; m_prev_c = 1;
    m_waiting = 0; m_finishing = 0; m_err = 0;
    m_wa = '0; m_wd = '0; m_disp = '0;
  endtask

  task automatic model_step();
    bit          ee, ce, new_err;
    logic [31:0] v;
    if (rst) begin
      model_reset();
      return;
    end
    ee = btn_enter && !m_prev_e;
    ce = btn_commit && !m_prev_c;
    v  = m_value();
    new_err = 0;
    if (m_finishing) begin
      m_finishing = 0;
      nibs.delete();
    end else if (m_waiting) begin
      if (ack) begin
        m_waiting   = 0;
        m_finishing = 1;
      end
    end else if (!mode_en) begin
      nibs.delete();
    end else if (nibs.size() > 0 && ce) begin
      m_wa = addr;
      m_wd = v;
      if (addr == 0) begin
        new_err = 1;
        nibs.delete();
      end else begin
        m_waiting = 1;
      end
    end else if (ee) begin
      nibs.push_back(int'(digit));
      if (nibs.size() > NIB_MAX) void'(nibs.pop_front());
    end
    m_err    = new_err;
    m_disp   = disp_hi ? v[31:16] : v[15:0];
    m_prev_e = btn_enter;
    m_prev_c = btn_commit;
  endtask

  task automatic compare_all();
    check_eq("wr_req",  32'(wr_if.wr_req),  32'(m_waiting));
    check_eq("wr_addr", 32'(wr_if.wr_addr), 32'(m_wa));
    check_eq("wr_data", wr_if.wr_data,      m_wd);
    check_eq("busy",    32'(busy),          32'(m_waiting | m_finishing));
    check_eq("done",    32'(done),          32'(m_finishing));
    check_eq("err",     32'(err),           32'(m_err));
    check_eq("nib_cnt", 32'(nib_cnt),       32'(nibs.size()));
    check_eq("disp",    32'(disp_val),      32'(m_disp));
    check_eq("done_err_excl", 32'(done & err), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic press_enter(input logic [3:0] d);
    btn_enter = 1; digit = d;
    tick();
    btn_enter = 0;
    tick();
  endtask

  task automatic press_commit(input logic [4:0] a);
    btn_commit = 1; addr = a;
    tick();
    btn_commit = 0;
  endtask

  initial begin
    model_reset();
    rst = 1; mode_en = 0; btn_enter = 0; btn_commit = 0; disp_hi = 0;
    ack = 0; digit = '0; addr = '0;
    tick(); tick();
    check_eq("rst_nib", 32'(nib_cnt), 32'd0);
    check_eq("rst_req", 32'(wr_if.wr_req), 32'd0);
    rst = 0; mode_en = 1; ack = 1;
    tick();

    // Basic write of 0x12345678 to r5
    for (int unsigned i = 1; i <= 8; i++) press_enter(4'(i));
    press_commit(5'd5);
    check_eq("s1_req",  32'(wr_if.wr_req), 32'd1);
    check_eq("s1_addr", 32'(wr_if.wr_addr), 32'd5);
    check_eq("s1_data", wr_if.wr_data, 32'h12345678);
    tick();
    check_eq("s1_done", 32'(done), 32'd1);
    check_eq("s1_req_fall", 32'(wr_if.wr_req), 32'd0);
    tick();
    check_eq("s1_nib0", 32'(nib_cnt), 32'd0);

    // Saturation with ten digits and both display halves
    for (int unsigned i = 0; i < 10; i++) press_enter(4'(i));
    check_eq("s2_nib", 32'(nib_cnt), 32'd8);
    disp_hi = 1; tick();
    check_eq("s2_disp_hi", 32'(disp_val), 32'h2345);
    disp_hi = 0; tick();
    check_eq("s2_disp_lo", 32'(disp_val), 32'h6789);
    mode_en = 0; tick();
    check_eq("s2_mode_clr", 32'(nib_cnt), 32'd0);
    mode_en = 1; tick();

    // Commit to register 0
    press_enter(4'hA); press_enter(4'hB);
    press_commit(5'd0);
    check_eq("s3_err", 32'(err), 32'd1);
    check_eq("s3_noreq", 32'(wr_if.wr_req), 32'd0);
    tick();
    check_eq("s3_err_pulse", 32'(err), 32'd0);
    tick();
    check_eq("s3_disp0", 32'(disp_val), 32'd0);

    // Delayed ack with button activity during REQ
    ack = 0;
    press_enter(4'h9); press_enter(4'hC);
    press_commit(5'd3);
    for (int unsigned i = 0; i < 5; i++) begin
      btn_enter = i[0]; btn_commit = ~i[0];
      tick();
      check_eq("s4_req_held", 32'(wr_if.wr_req), 32'd1);
      check_eq("s4_data_held", wr_if.wr_data, 32'h9C);
    end
    btn_enter = 0; btn_commit = 0; ack = 1;
    tick();
    check_eq("s4_done", 32'(done), 32'd1);
    tick();

    // Simultaneous enter and commit: commit wins
    press_enter(4'hF);
    btn_enter = 1; digit = 4'h3; btn_commit = 1; addr = 5'd2;
    tick();
    check_eq("s5_data", wr_if.wr_data, 32'h0000000F);
    btn_enter = 0; btn_commit = 0;
    tick(); tick();

    // Enter held through reset release
    rst = 1; btn_enter = 1; digit = 4'h5;
    tick(); tick();
    rst = 0;
    tick(); tick();
    check_eq("s6_no_entry", 32'(nib_cnt), 32'd0);
    btn_enter = 0; tick();

    // Reset during REQ
    ack = 0;
    press_enter(4'h4);
    press_commit(5'd9);
    check_eq("s6_req", 32'(wr_if.wr_req), 32'd1);
    rst = 1; tick();
    check_eq("s6_req_drop", 32'(wr_if.wr_req), 32'd0);
    rst = 0; ack = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check_eq("s6_no_done", 32'(done), 32'd0);
    end

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      mode_en = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 2) == 0) btn_enter = ~btn_enter;
      if ($urandom_range(0, 9) == 0) btn_commit = ~btn_commit;
      digit   = 4'($urandom);
      addr    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      ack     = ($urandom_range(0, 2) == 0);
      disp_hi = 1'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
